// File: rtl/seven_segment_decoder.sv
// Seven-segment pattern debouncer and decoder with a valid/ready output handshake.
// A pattern is accepted once it has been sampled STABLE_CYCLES consecutive times.
// The same pattern is not accepted twice in a row.
// Legal hex patterns produce a digit. 7'h00 sets blank. Any other pattern raises illegal.
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       out_ready,
    output logic [3:0] digit,
    output logic       out_valid,
    output logic       overrun,
    output logic       illegal,
    output logic [6:0] illegal_code,
    output logic       blank
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned CNT_W = 4;

    logic [SEG_W-1:0] r_prev_seg;
    logic [CNT_W-1:0] r_count;
    logic [SEG_W-1:0] r_last_acc;
    logic             r_has_acc;

    logic [DIG_W-1:0] w_dec;
    logic             w_dec_ok;
    logic             w_match;
    logic             w_accept;
    logic             w_acc_legal;
    logic             w_acc_blank;
    logic             w_acc_illegal;
    logic             w_consume;

    logic [SEG_W-1:0] w_prev_seg_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [SEG_W-1:0] w_last_acc_nxt;
    logic             w_has_acc_nxt;
    logic [DIG_W-1:0] w_digit_nxt;
    logic             w_valid_nxt;
    logic             w_overrun_nxt;
    logic             w_illegal_nxt;
    logic [SEG_W-1:0] w_illegal_code_nxt;
    logic             w_blank_nxt;

    // Map a segment pattern to its hex value; w_dec_ok flags a recognised pattern.
    always_comb begin
        w_dec    = '0;
        w_dec_ok = 1'b1;
        case (segments)
            7'h7E:   w_dec = 4'h0;
            7'h30:   w_dec = 4'h1;
            7'h6D:   w_dec = 4'h2;
            7'h79:   w_dec = 4'h3;
            7'h33:   w_dec = 4'h4;
            7'h5B:   w_dec = 4'h5;
            7'h5F:   w_dec = 4'h6;
            7'h70:   w_dec = 4'h7;
            7'h7F:   w_dec = 4'h8;
            7'h7B:   w_dec = 4'h9;
            7'h77:   w_dec = 4'hA;
            7'h1F:   w_dec = 4'hB;
            7'h4E:   w_dec = 4'hC;
            7'h3D:   w_dec = 4'hD;
            7'h4F:   w_dec = 4'hE;
            7'h47:   w_dec = 4'hF;
            default: w_dec_ok = 1'b0;
        endcase
    end

    // Stability tracking, acceptance and the output handshake as next-state logic.
    always_comb begin
        w_prev_seg_nxt     = r_prev_seg;
        w_count_nxt        = r_count;
        w_last_acc_nxt     = r_last_acc;
        w_has_acc_nxt      = r_has_acc;
        w_digit_nxt        = digit;
        w_valid_nxt        = out_valid;
        w_overrun_nxt      = 1'b0;
        w_illegal_nxt      = 1'b0;
        w_illegal_code_nxt = illegal_code;
        w_blank_nxt        = blank;

        w_match       = (segments == r_prev_seg);
        w_accept      = w_match && (r_count == CNT_W'(STABLE_CYCLES - 1))
                        && (!r_has_acc || (segments != r_last_acc));
        w_acc_legal   = w_accept && w_dec_ok;
        w_acc_blank   = w_accept && (segments == '0);
        w_acc_illegal = w_accept && !w_dec_ok && (segments != '0);
        w_consume     = out_valid && out_ready;

        if (!w_match) begin
            w_prev_seg_nxt = segments;
            w_count_nxt    = CNT_W'(1);
        end else if (r_count < CNT_W'(STABLE_CYCLES)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end

        if (w_accept) begin
            w_last_acc_nxt = segments;
            w_has_acc_nxt  = 1'b1;
        end

        if (w_consume) begin
            w_valid_nxt = 1'b0;
        end

        if (w_acc_legal) begin
            w_digit_nxt   = w_dec;
            w_valid_nxt   = 1'b1;
            w_blank_nxt   = 1'b0;
            w_overrun_nxt = out_valid && !out_ready;
        end

        if (w_acc_blank) begin
            w_blank_nxt = 1'b1;
        end

        if (w_acc_illegal) begin
            w_illegal_nxt      = 1'b1;
            w_illegal_code_nxt = segments;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_seg   <= '0;
            r_count      <= '0;
            r_last_acc   <= '0;
            r_has_acc    <= 1'b0;
            digit        <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            illegal      <= 1'b0;
            illegal_code <= '0;
            blank        <= 1'b0;
        end else begin
            r_prev_seg   <= w_prev_seg_nxt;
            r_count      <= w_count_nxt;
            r_last_acc   <= w_last_acc_nxt;
            r_has_acc    <= w_has_acc_nxt;
            digit        <= w_digit_nxt;
            out_valid    <= w_valid_nxt;
            overrun      <= w_overrun_nxt;
            illegal      <= w_illegal_nxt;
            illegal_code <= w_illegal_code_nxt;
            blank        <= w_blank_nxt;
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Testbench for seven_segment_decoder.
// Directed scenarios are followed by randomized pattern streams.
// Every edge is checked against a sample-history reference model.
module tb_seven_segment_decoder;

    localparam int unsigned SC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] segments = '0;
    logic       out_ready = 1'b0;
    logic [3:0] digit;
    logic       out_valid;
    logic       overrun;
    logic       illegal;
    logic [6:0] illegal_code;
    logic       blank;

    seven_segment_decoder #(.STABLE_CYCLES(SC)) dut (
        .clock        (clock),
        .reset        (reset),
        .segments     (segments),
        .out_ready    (out_ready),
        .digit        (digit),
        .out_valid    (out_valid),
        .overrun      (overrun),
        .illegal      (illegal),
        .illegal_code (illegal_code),
        .blank        (blank)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] table_seg [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference state: samples seen since reset plus the architectural outputs.
    logic [6:0] hist[$];
    logic       m_has_acc = 1'b0;
    logic [6:0] m_last_acc = '0;
    logic [3:0] m_digit = '0;
    logic       m_valid = 1'b0;
    logic       m_overrun = 1'b0;
    logic       m_illegal = 1'b0;
    logic [6:0] m_illegal_code = '0;
    logic       m_blank = 1'b0;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns the table index for a legal pattern, or -1 if the pattern is not a hex digit.
    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (table_seg[i] == s) return i;
        end
        return -1;
    endfunction

    // Apply one clock edge's worth of inputs, advance the model, and check all outputs.
    task automatic step(input logic [6:0] seg, input logic rdy, input logic rst);
        int  run;
        int  idx;
        bit  acc;
        bit  acc_legal;
        @(negedge clock);
        segments  = seg;
        out_ready = rdy;
        reset     = rst;
        @(posedge clock);
        if (rst) begin
            hist.delete();
            m_has_acc = 1'b0; m_last_acc = '0;
            m_digit = '0; m_valid = 1'b0; m_overrun = 1'b0;
            m_illegal = 1'b0; m_illegal_code = '0; m_blank = 1'b0;
        end else begin
            hist.push_back(seg);
            if (hist.size() > 20) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != seg) break;
                run++;
            end
            // Accept on exactly the SC-th consecutive identical sample since reset.
            acc = (run == int'(SC)) && (!m_has_acc || seg != m_last_acc);
            idx = lookup(seg);
            acc_legal = acc && (idx >= 0);
            m_overrun = acc_legal && m_valid && !rdy;
            m_illegal = acc && (idx < 0) && (seg != 0);
            if (m_valid && rdy) m_valid = 1'b0;
            if (acc_legal) begin
                m_digit = 4'(idx);
                m_valid = 1'b1;
                m_blank = 1'b0;
            end
            if (acc && seg == 0) m_blank = 1'b1;
            if (m_illegal) m_illegal_code = seg;
            if (acc) begin
                m_has_acc  = 1'b1;
                m_last_acc = seg;
            end
        end
        #1;
        check_eq("digit",        7'(digit),     7'(m_digit));
        check_eq("out_valid",    7'(out_valid), 7'(m_valid));
        check_eq("overrun",      7'(overrun),   7'(m_overrun));
        check_eq("illegal",      7'(illegal),   7'(m_illegal));
        check_eq("illegal_code", illegal_code,  m_illegal_code);
        check_eq("blank",        7'(blank),     7'(m_blank));
    endtask

    task automatic hold(input logic [6:0] seg, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(seg, rdy, 1'b0);
    endtask

    initial begin
        logic [6:0] pat;
        int         len;
        int         sel;

        // Reset state.
        step(7'h00, 1'b0, 1'b1);
        step(7'h00, 1'b0, 1'b1);

        // Digit 2 appears after the fourth identical sample; then consume it.
        hold(7'h6D, 1'b0, 5);
        hold(7'h6D, 1'b1, 2);

        // Short 1 is rejected; stable 3 is accepted.
        hold(7'h30, 1'b0, 2);
        hold(7'h79, 1'b0, 4);
        hold(7'h79, 1'b1, 1);

        // Overwrite of an unconsumed 5 by F pulses overrun.
        hold(7'h5B, 1'b0, 4);
        hold(7'h47, 1'b0, 5);
        // Same again, but ready on the acceptance edge: no overrun.
        hold(7'h5B, 1'b0, 4);
        hold(7'h47, 1'b0, 3);
        hold(7'h47, 1'b1, 1);
        hold(7'h47, 1'b0, 2);
        hold(7'h47, 1'b1, 1);

        // Glitch away and back does not re-accept.
        hold(7'h7F, 1'b0, 4);
        hold(7'h7B, 1'b0, 1);
        hold(7'h7F, 1'b0, 5);
        hold(7'h7F, 1'b1, 3);

        // Illegal, blank, then A.
        hold(7'h01, 1'b0, 5);
        hold(7'h00, 1'b0, 5);
        hold(7'h77, 1'b0, 5);

        // Reset mid-count and with valid pending.
        hold(7'h6D, 1'b0, 2);
        step(7'h6D, 1'b0, 1'b1);
        hold(7'h00, 1'b0, 5);
        hold(7'h33, 1'b0, 5);
        step(7'h33, 1'b0, 1'b1);
        hold(7'h33, 1'b0, 6);

        // Randomized pattern streams with random hold lengths, ready, and occasional reset.
        for (int k = 0; k < 600; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      pat = table_seg[$urandom_range(0, 15)];
            else if (sel < 7) pat = 7'h00;
            else              pat = 7'($urandom);
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                step(pat, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted; legal range 2..15.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port segments  input  7  segment lines, active high, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 SHALL have port out_ready  input  1  consumer accepts digit when high with out_valid.
REQ-006 SHALL have port digit  output  4  decoded hex value, registered.
REQ-007 SHALL have port out_valid  output  1  digit holds an unconsumed accepted value.
REQ-008 SHALL have port overrun  output  1  one-cycle pulse: unconsumed digit overwritten.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse: stable non-hex, non-blank pattern accepted.
REQ-010 SHALL have port illegal_code  output  7  last illegal pattern, registered.
REQ-011 SHALL have port blank  output  1  level: last accepted pattern was 7'h00.

Function
REQ-012 SHALL decode 7'h7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47 to 4'h0..4'hF respectively; all other nonzero patterns are illegal.
REQ-013 SHALL keep prev_seg (7b) and count (width holding 0..STABLE_CYCLES); each edge: segments != prev_seg -> prev_seg<=segments, count<=1; else count<STABLE_CYCLES -> count<=count+1; else hold.
REQ-014 SHALL accept on the edge where segments == prev_seg and count == STABLE_CYCLES-1, provided no acceptance has occurred since reset or the pattern differs from last_accepted (7b register).
REQ-015 SHALL update last_accepted on every acceptance; a stable pattern that glitches away and returns unchanged before another acceptance SHALL NOT be accepted again.
REQ-016 SHALL give latency: pattern first sampled at edge N, held -> acceptance effects visible after edge N+STABLE_CYCLES-1.
REQ-017 On legal acceptance: digit<=decoded value, out_valid<=1, blank<=0.
REQ-018 On blank (7'h00) acceptance: blank<=1, digit and out_valid unaffected except by REQ-020.
REQ-019 On illegal acceptance: illegal pulses 1 cycle, illegal_code<=pattern, digit/out_valid/blank unchanged.
REQ-020 Handshake: out_valid && out_ready at an edge consumes; out_valid<=0 unless a legal acceptance occurs on the same edge, in which case out_valid stays 1 with new digit and overrun stays 0.
REQ-021 Legal acceptance while out_valid=1 and out_ready=0: digit overwritten, out_valid stays 1, overrun pulses 1 cycle.
REQ-022 digit SHALL remain stable while out_valid=1 and no legal acceptance occurs.
REQ-023 overrun and illegal SHALL be low on every edge with no corresponding event.

Reset
REQ-024 reset high at an edge SHALL force digit=0, out_valid=0, overrun=0, illegal=0, illegal_code=0, blank=0, prev_seg=0, count=0, acceptance history cleared; reset takes priority over all other events.
REQ-025 reset mid-count or with out_valid=1 SHALL discard pending state; the held input after reset release is treated as a new pattern (segments=7'h00 held -> blank after STABLE_CYCLES-1 further edges).

Verification
REQ-026 STABLE_CYCLES=4, out_ready=0, segments=7'h6D held from edge 1 -> digit=2, out_valid=1 after edge 4; low after edge 3.
REQ-027 7'h30 held 2 edges, 7'h79 held 4 edges -> only digit=3 accepted; no value for 1.
REQ-028 digit=5 valid, out_ready=0, then 7'h47 stable -> digit=F, overrun pulse 1 cycle; repeat with out_ready=1 on acceptance edge -> overrun=0, out_valid=1.
REQ-029 7'h7F stable, glitch 7'h7B one edge, back to 7'h7F -> no second acceptance; after consumption out_valid stays 0.
REQ-030 7'h01 stable -> illegal pulse, illegal_code=7'h01, out_valid unchanged; 7'h00 stable -> blank=1; then 7'h77 -> blank=0, digit=A.
REQ-031 reset asserted during count and while out_valid=1 -> all outputs zero next cycle; no stale acceptance afterward.
